// File: rtl/serial_mag_cmp_ctrl_pkg.sv
// Shared definitions for the bit-serial magnitude comparator controller.
//   - FSM state encodings (IDLE / SHIFT / DONE)
//   - bit positions of lt/eq/gt inside the packed result word
//   - helpers to build a result word and size the bit-index counter
package serial_mag_cmp_ctrl_pkg;

    localparam logic [1:0] CMP_IDLE  = 2'd0;
    localparam logic [1:0] CMP_SHIFT = 2'd1;
    localparam logic [1:0] CMP_DONE  = 2'd2;

    // Packed result word layout: {lt, eq, gt}
    localparam int RES_LT = 2;
    localparam int RES_EQ = 1;
    localparam int RES_GT = 0;

    typedef logic [2:0] cmp_res_t;

    function automatic cmp_res_t pack_res(input logic lt, input logic eq, input logic gt);
        cmp_res_t r;
        r         = '0;
        r[RES_LT] = lt;
        r[RES_EQ] = eq;
        r[RES_GT] = gt;
        return r;
    endfunction

    // Bit-index counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_mag_cmp_ctrl_comparator.sv
// 1-bit magnitude comparator cell.
// Ports:
//   a, b : input bits
//   l    : a < b
//   e    : a == b
//   g    : a > b
module comparator (
    input  logic a,
    input  logic b,
    output logic l,
    output logic e,
    output logic g
);

    assign l = ~a & b;
    assign e = ~(a ^ b);
    assign g = a & ~b;

endmodule

// File: rtl/serial_mag_cmp_ctrl.sv
// Bit-serial magnitude comparator controller.
// Compares two WIDTH-bit operands MSB first through a single 1-bit
// comparator cell, with a start/busy/done handshake and a registered,
// one-hot lt/eq/gt result.
//
// Parameters:
//   WIDTH      operand width (>= 1)
//   SIGNED     1: two's complement operands (sign-bit cell outputs swapped)
//   EARLY_EXIT 1: finish on the first differing bit; 0: always scan WIDTH bits
//
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   start  compare request, accepted in IDLE or DONE
//   a_in   operand A, captured on the accepted start edge
//   b_in   operand B, captured on the accepted start edge
//   busy   high while scanning bits
//   done   one-cycle pulse, result just updated
//   lt     A < B
//   eq     A == B
//   gt     A > B
//
// state     | meaning
// ----------+-----------------------------------------------------------
// CMP_IDLE  | waiting for start, result held
// CMP_SHIFT | one operand bit pair per cycle through the cell, MSB first
// CMP_DONE  | result updated this cycle; start here chains a new compare
module serial_mag_cmp_ctrl
    import serial_mag_cmp_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SIGNED     = 0,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int            CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0] IDX_MSB = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    idx;
    cmp_res_t         res;

    // First difference seen so far; needed when scanning past it.
    logic seen_lt;
    logic seen_gt;

    logic cell_l;
    logic cell_e;
    logic cell_g;
    logic msb_swap;
    logic bit_lt;
    logic bit_gt;
    logic decided;
    logic acc_lt;
    logic acc_gt;

    comparator u_cell (
        .a (a_sh[WIDTH-1]),
        .b (b_sh[WIDTH-1]),
        .l (cell_l),
        .e (cell_e),
        .g (cell_g)
    );

    // For two's complement the sign bit has inverted weight: a set sign
    // bit makes the operand smaller, so l and g trade places there.
    assign msb_swap = (SIGNED != 0) && (idx == IDX_MSB);
    assign bit_lt   = msb_swap ? cell_g : cell_l;
    assign bit_gt   = msb_swap ? cell_l : cell_g;

    // The most significant differing bit decides the order; later bits
    // only matter while nothing has been decided yet.
    assign decided  = seen_lt | seen_gt;
    assign acc_lt   = decided ? seen_lt : bit_lt;
    assign acc_gt   = decided ? seen_gt : bit_gt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CMP_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            idx     <= '0;
            res     <= '0;
            seen_lt <= 1'b0;
            seen_gt <= 1'b0;
        end else begin
            case (state)
                CMP_IDLE, CMP_DONE: begin
                    if (start) begin
                        a_sh    <= a_in;
                        b_sh    <= b_in;
                        idx     <= IDX_MSB;
                        seen_lt <= 1'b0;
                        seen_gt <= 1'b0;
                        state   <= CMP_SHIFT;
                    end else begin
                        state   <= CMP_IDLE;
                    end
                end

                CMP_SHIFT: begin
                    a_sh    <= a_sh << 1;
                    b_sh    <= b_sh << 1;
                    seen_lt <= acc_lt;
                    seen_gt <= acc_gt;
                    if (idx != '0) begin
                        idx <= idx - 1'b1;
                    end

                    if ((EARLY_EXIT != 0) && !cell_e) begin
                        res   <= pack_res(bit_lt, 1'b0, bit_gt);
                        state <= CMP_DONE;
                    end else if (idx == '0) begin
                        res   <= pack_res(acc_lt, ~(acc_lt | acc_gt), acc_gt);
                        state <= CMP_DONE;
                    end
                end

                default: begin
                    state <= CMP_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == CMP_SHIFT);
    assign done = (state == CMP_DONE);
    assign lt   = res[RES_LT];
    assign eq   = res[RES_EQ];
    assign gt   = res[RES_GT];

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Self-checking bench: five comparator controllers with different
// parameter sets share one stimulus stream; a behavioural model predicts
// busy/done/lt/eq/gt for each from plain integer comparison and the
// documented latency rules.
module tb_serial_mag_cmp_ctrl;

    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;

    logic d_busy [N];
    logic d_done [N];
    logic d_lt   [N];
    logic d_eq   [N];
    logic d_gt   [N];

    always #5 clk = ~clk;

    // inst0: unsigned early-exit   inst1: unsigned full scan
    // inst2: signed early-exit     inst3: signed full scan
    // inst4: 1-bit signed early-exit
    serial_mag_cmp_ctrl #(.WIDTH(8), .SIGNED(0), .EARLY_EXIT(1)) u0 (
        .clk(clk), .rst(rst), .start(start), .a_in(a), .b_in(b),
        .busy(d_busy[0]), .done(d_done[0]), .lt(d_lt[0]), .eq(d_eq[0]), .gt(d_gt[0]));
    serial_mag_cmp_ctrl #(.WIDTH(8), .SIGNED(0), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst(rst), .start(start), .a_in(a), .b_in(b),
        .busy(d_busy[1]), .done(d_done[1]), .lt(d_lt[1]), .eq(d_eq[1]), .gt(d_gt[1]));
    serial_mag_cmp_ctrl #(.WIDTH(8), .SIGNED(1), .EARLY_EXIT(1)) u2 (
        .clk(clk), .rst(rst), .start(start), .a_in(a), .b_in(b),
        .busy(d_busy[2]), .done(d_done[2]), .lt(d_lt[2]), .eq(d_eq[2]), .gt(d_gt[2]));
    serial_mag_cmp_ctrl #(.WIDTH(8), .SIGNED(1), .EARLY_EXIT(0)) u3 (
        .clk(clk), .rst(rst), .start(start), .a_in(a), .b_in(b),
        .busy(d_busy[3]), .done(d_done[3]), .lt(d_lt[3]), .eq(d_eq[3]), .gt(d_gt[3]));
    serial_mag_cmp_ctrl #(.WIDTH(1), .SIGNED(1), .EARLY_EXIT(1)) u4 (
        .clk(clk), .rst(rst), .start(start), .a_in(a[0:0]), .b_in(b[0:0]),
        .busy(d_busy[4]), .done(d_done[4]), .lt(d_lt[4]), .eq(d_eq[4]), .gt(d_gt[4]));

    function automatic int w_of(input int i);
        return (i == 4) ? 1 : 8;
    endfunction

    function automatic bit s_of(input int i);
        return (i >= 2);
    endfunction

    function automatic bit e_of(input int i);
        return (i == 0) || (i == 2) || (i == 4);
    endfunction

    // Model state: busy/done flags, remaining scan cycles, result {lt,eq,gt}.
    bit         m_busy [N];
    bit         m_done [N];
    int         m_cnt  [N];
    logic [2:0] m_res  [N];
    logic [2:0] m_pend [N];

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // Ordering by integer value; scan length is WIDTH, or with early exit
    // the number of bits down to and including the first differing one.
    function automatic void model_cmp(input int w, input bit s, input bit e,
                                      input logic [7:0] x, input logic [7:0] y,
                                      output int nsh, output logic [2:0] res);
        int xv;
        int yv;
        int k;
        xv = 0;
        yv = 0;
        for (int j = 0; j < w; j++) begin
            if (x[j]) xv += (1 << j);
            if (y[j]) yv += (1 << j);
        end
        if (s && x[w-1]) xv -= (1 << w);
        if (s && y[w-1]) yv -= (1 << w);
        res = (xv < yv) ? 3'b100 : ((xv == yv) ? 3'b010 : 3'b001);
        k = -1;
        for (int j = w - 1; j >= 0; j--) begin
            if (k < 0 && x[j] != y[j]) k = j;
        end
        nsh = (k < 0 || !e) ? w : (w - k);
    endfunction

    task automatic model_edge();
        int         nsh;
        logic [2:0] r;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_cnt[i]  = 0;
                m_res[i]  = 3'b000;
            end else if (m_busy[i]) begin
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 0) begin
                    m_busy[i] = 1'b0;
                    m_done[i] = 1'b1;
                    m_res[i]  = m_pend[i];
                end
            end else begin
                m_done[i] = 1'b0;
                if (start) begin
                    model_cmp(w_of(i), s_of(i), e_of(i), a, b, nsh, r);
                    m_busy[i] = 1'b1;
                    m_cnt[i]  = nsh;
                    m_pend[i] = r;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [4:0] act;
        logic [4:0] exp;
        for (int i = 0; i < N; i++) begin
            act = {d_busy[i], d_done[i], d_lt[i], d_eq[i], d_gt[i]};
            exp = {m_busy[i], m_done[i], m_res[i]};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL model_check inst%0d cyc%0d: busy/done/lt/eq/gt got %b expected %b",
                         i, cyc, act, exp);
            end
        end
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; model advances with the rising
    // edge and is compared at the next falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    function automatic int res_of(input int i);
        return int'({d_lt[i], d_eq[i], d_gt[i]});
    endfunction

    int lat   [N];
    int bcnt  [N];

    // One compare with a single-cycle start; lat[i] = done cycle - start edge.
    task automatic run_one(input logic [7:0] x, input logic [7:0] y);
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            lat[i]  = -1;
            bcnt[i] = d_busy[i] ? 1 : 0;
        end
        for (int j = 1; j <= 12; j++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (d_done[i] && lat[i] < 0) lat[i] = j + 1;
                if (d_busy[i]) bcnt[i]++;
            end
        end
    endtask

    task automatic wait_done(input int i, input string name);
        int n;
        n = 0;
        while (!d_done[i] && n < 30) begin
            tick();
            n++;
        end
        check_lit({name, "_timeout"}, int'(d_done[i]), 1);
    endtask

    initial begin
        int nd;
        logic [7:0] flip;

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
            m_cnt[i]  = 0;
            m_res[i]  = 3'b000;
            m_pend[i] = 3'b000;
        end

        repeat (3) tick();
        check_lit("reset_outputs", int'({d_busy[0], d_done[0], d_lt[0], d_eq[0], d_gt[0]}), 0);
        rst = 1'b0;
        tick();

        // Reset held mid-scan
        a     = 8'hF0;
        b     = 8'h0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_lit("midshift_busy", int'(d_busy[1]), 1);
        rst = 1'b1;
        repeat (3) tick();
        check_lit("midshift_reset_outs",
                  int'({d_busy[1], d_done[1], d_lt[1], d_eq[1], d_gt[1]}), 0);
        rst = 1'b0;
        nd  = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (d_done[1]) nd++;
        end
        check_lit("no_done_after_reset", nd, 0);

        // Equal operands, full scan
        run_one(8'hA5, 8'hA5);
        check_lit("eq_full_latency", lat[1], 9);
        check_lit("eq_full_busy_cycles", bcnt[1], 8);
        check_lit("eq_full_result", res_of(1), 3'b010);
        check_lit("eq_early_latency", lat[0], 9);

        // MSB differs: early exit vs full scan, unsigned and signed views
        run_one(8'h80, 8'h7F);
        check_lit("early_latency", lat[0], 2);
        check_lit("early_result_gt", res_of(0), 3'b001);
        check_lit("full_latency", lat[1], 9);
        check_lit("full_result_gt", res_of(1), 3'b001);
        check_lit("signed_80_7f_lt", res_of(2), 3'b100);

        // Signed ordering
        run_one(8'hFF, 8'h01);
        check_lit("signed_m1_lt_1", res_of(2), 3'b100);
        check_lit("signed_full_m1_lt_1", res_of(3), 3'b100);
        check_lit("unsigned_ff_gt_01", res_of(0), 3'b001);
        run_one(8'h80, 8'h80);
        check_lit("signed_80_eq", res_of(3), 3'b010);

        // 1-bit signed: 1 is -1, so 1 < 0
        run_one(8'h01, 8'h00);
        check_lit("w1_signed_lt", res_of(4), 3'b100);
        check_lit("w1_latency", lat[4], 2);

        // Back-to-back with start held high
        a     = 8'd3;
        b     = 8'd5;
        start = 1'b1;
        tick();
        wait_done(0, "b2b_first");
        check_lit("b2b_first_lt", res_of(0), 3'b100);
        a = 8'd5;
        b = 8'd3;
        tick();
        check_lit("b2b_no_idle_busy", int'(d_busy[0]), 1);
        wait_done(0, "b2b_second");
        check_lit("b2b_second_gt", res_of(0), 3'b001);
        start = 1'b0;
        repeat (12) tick();

        // start during scan with new operands is ignored
        a     = 8'h10;
        b     = 8'h20;
        start = 1'b1;
        tick();
        a = 8'hFF;
        b = 8'h00;
        tick();
        tick();
        start = 1'b0;
        wait_done(0, "ignore_start");
        check_lit("ignore_start_lt", res_of(0), 3'b100);
        wait_done(1, "ignore_start_full");
        check_lit("ignore_start_full_lt", res_of(1), 3'b100);
        repeat (12) tick();

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 79) == 0);
            start = ($urandom_range(0, 2) != 0);
            a     = 8'($urandom);
            case ($urandom_range(0, 2))
                0: b = a;
                1: begin
                    flip = 8'd1 << $urandom_range(0, 7);
                    b    = a ^ flip;
                end
                default: b = 8'($urandom);
            endcase
            tick();
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
